// File: rtl/freq_drive_gen_if.sv
// Bundle between the frequency-sweep controller and the gate-drive generator.
// The sweep side owns the request and enable; the generator owns the drives and status.
interface freq_drive_gen_if #(
    parameter int unsigned HP_W = 16
) ();
    logic            swiptAlive;
    logic [19:0]     newFreq;
    logic            driveA;
    logic            driveB;
    logic            periodStart;
    logic [19:0]     freqApplied;
    logic [HP_W-1:0] halfPeriod;
    logic            locked;

    modport master (
        output swiptAlive, newFreq,
        input  driveA, driveB, periodStart, freqApplied, halfPeriod, locked
    );

    modport slave (
        input  swiptAlive, newFreq,
        output driveA, driveB, periodStart, freqApplied, halfPeriod, locked
    );
endinterface

// File: rtl/freq_drive_gen.sv
// Frequency request to dead-time-protected complementary gate drive for the SWIPT bridge.
// A serial restoring divider turns Hz into a half-period count; new values swap at period ends.
module freq_drive_gen #(
    parameter int unsigned CLK_HZ      = 100000000,
    parameter int unsigned MIN_FREQ    = 20000,
    parameter int unsigned MAX_FREQ    = 500000,
    parameter int unsigned DEAD_CYCLES = 10,
    parameter int unsigned HP_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    freq_drive_gen_if.slave  bus
);

    localparam int unsigned CW = HP_W + 1;
    localparam logic [CW-1:0] CntOne = 1;

    if ((CLK_HZ / (2 * MIN_FREQ)) >= (1 << HP_W) ||
        (CLK_HZ / (2 * MAX_FREQ)) < (2 * DEAD_CYCLES)) begin : g_bad_params
        $error("freq_drive_gen: half-period range does not fit HP_W or dead time");
    end

    typedef enum logic [1:0] {
        StIdle,
        StDivide,
        StRun,
        StRunDiv
    } state_e;

    state_e          state_q, state_d;
    logic [19:0]     req_freq_q, req_freq_d;
    logic [31:0]     rem_q, rem_d;
    logic [31:0]     quo_q, quo_d;
    logic [4:0]      step_q, step_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic [19:0]     fa_q, fa_d;
    logic            pend_valid_q, pend_valid_d;
    logic [HP_W-1:0] pend_hp_q, pend_hp_d;
    logic [19:0]     pend_freq_q, pend_freq_d;
    logic            drive_a_q, drive_a_d;
    logic            drive_b_q, drive_b_d;
    logic            pstart_q, pstart_d;

    logic [19:0]     req_in;
    logic [31:0]     divisor;
    logic [32:0]     rem_shift;
    logic            fits;
    logic            chg;
    logic            running;
    logic            wrap;

    always_comb begin
        req_in = bus.newFreq;
        if (bus.newFreq < 20'(MIN_FREQ)) begin
            req_in = 20'(MIN_FREQ);
        end else if (bus.newFreq > 20'(MAX_FREQ)) begin
            req_in = 20'(MAX_FREQ);
        end
    end

    // Dividend bits are shifted out of the top of quo_q while quotient bits enter at the bottom.
    assign divisor   = {11'd0, req_freq_q, 1'b0};
    assign rem_shift = {rem_q, quo_q[31]};
    assign fits      = rem_shift >= {1'b0, divisor};

    assign chg     = bus.swiptAlive && (req_in != req_freq_q);
    assign running = (state_q == StRun) || (state_q == StRunDiv);
    assign wrap    = cnt_q == ({hp_q, 1'b0} - CntOne);

    always_comb begin
        state_d      = state_q;
        req_freq_d   = req_freq_q;
        rem_d        = rem_q;
        quo_d        = quo_q;
        step_d       = step_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        cnt_d        = cnt_q;
        hp_d         = hp_q;
        fa_d         = fa_q;
        pend_valid_d = pend_valid_q;
        pend_hp_d    = pend_hp_q;
        pend_freq_d  = pend_freq_q;
        drive_a_d    = 1'b0;
        drive_b_d    = 1'b0;
        pstart_d     = 1'b0;

        if (busy_q) begin
            rem_d  = fits ? 32'(rem_shift - {1'b0, divisor}) : rem_shift[31:0];
            quo_d  = {quo_q[30:0], fits};
            step_d = step_q + 5'd1;
            if (step_q == 5'd31) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end

        if (!bus.swiptAlive) begin
            // Link loss: drives off, request forgotten, applied values retained for status.
            state_d      = StIdle;
            req_freq_d   = '0;
            busy_d       = 1'b0;
            done_d       = 1'b0;
            pend_valid_d = 1'b0;
            cnt_d        = '0;
        end else begin
            if (running) begin
                cnt_d = wrap ? '0 : cnt_q + CntOne;
                if (wrap && pend_valid_q) begin
                    hp_d         = pend_hp_q;
                    fa_d         = pend_freq_q;
                    pend_valid_d = 1'b0;
                end
            end

            if (done_q && !chg) begin
                unique case (state_q)
                    StDivide: begin
                        state_d = StRun;
                        cnt_d   = '0;
                        hp_d    = quo_q[HP_W-1:0];
                        fa_d    = req_freq_q;
                    end
                    StRunDiv: begin
                        state_d      = StRun;
                        pend_valid_d = 1'b1;
                        pend_hp_d    = quo_q[HP_W-1:0];
                        pend_freq_d  = req_freq_q;
                    end
                    default: ;
                endcase
            end

            if (chg) begin
                req_freq_d = req_in;
                rem_d      = '0;
                quo_d      = CLK_HZ;
                step_d     = '0;
                busy_d     = 1'b1;
                done_d     = 1'b0;
                state_d    = running ? StRunDiv : StDivide;
            end

            // Drives are decoded from the next count so they come straight from flops.
            if ((state_d == StRun) || (state_d == StRunDiv)) begin
                drive_a_d = cnt_d < ({1'b0, hp_d} - CW'(DEAD_CYCLES));
                drive_b_d = (cnt_d >= {1'b0, hp_d}) &&
                            (cnt_d < ({hp_d, 1'b0} - CW'(DEAD_CYCLES)));
                pstart_d  = cnt_d == '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            req_freq_q   <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            step_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cnt_q        <= '0;
            hp_q         <= '0;
            fa_q         <= '0;
            pend_valid_q <= 1'b0;
            pend_hp_q    <= '0;
            pend_freq_q  <= '0;
            drive_a_q    <= 1'b0;
            drive_b_q    <= 1'b0;
            pstart_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_freq_q   <= req_freq_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            step_q       <= step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cnt_q        <= cnt_d;
            hp_q         <= hp_d;
            fa_q         <= fa_d;
            pend_valid_q <= pend_valid_d;
            pend_hp_q    <= pend_hp_d;
            pend_freq_q  <= pend_freq_d;
            drive_a_q    <= drive_a_d;
            drive_b_q    <= drive_b_d;
            pstart_q     <= pstart_d;
        end
    end

    assign bus.driveA      = drive_a_q;
    assign bus.driveB      = drive_b_q;
    assign bus.periodStart = pstart_q;
    assign bus.freqApplied = fa_q;
    assign bus.halfPeriod  = hp_q;
    assign bus.locked      = (state_q == StRun) && !pend_valid_q && !busy_q && !done_q &&
                             (fa_q == req_freq_q);

endmodule

// File: tb/tb_freq_drive_gen.sv
// Scoreboarded bench for freq_drive_gen: requests push expected (freq, half-period) pairs,
// a monitor pops them at period starts and measures every complete period and dead gap.
module tb_freq_drive_gen;

    localparam int unsigned CLK_HZ   = 100000000;
    localparam int unsigned MIN_FREQ = 20000;
    localparam int unsigned MAX_FREQ = 500000;
    localparam int unsigned DEAD     = 10;
    localparam int unsigned HP_W     = 16;

    typedef struct {
        int unsigned f;
        int unsigned hp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    freq_drive_gen_if #(.HP_W(HP_W)) bus ();

    freq_drive_gen #(
        .CLK_HZ     (CLK_HZ),
        .MIN_FREQ   (MIN_FREQ),
        .MAX_FREQ   (MAX_FREQ),
        .DEAD_CYCLES(DEAD),
        .HP_W       (HP_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    exp_t        exp_q[$];
    int unsigned req_model = 0;
    bit          meas_abort = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int unsigned clamp(input int unsigned f);
        if (f < MIN_FREQ) return MIN_FREQ;
        if (f > MAX_FREQ) return MAX_FREQ;
        return f;
    endfunction

    // Any change of the clamped request while alive must eventually be applied.
    task automatic model_update();
        int unsigned c;
        c = clamp(bus.newFreq);
        if (bus.swiptAlive && !rst && c != req_model) begin
            exp_t e;
            req_model = c;
            e.f  = c;
            e.hp = CLK_HZ / (2 * c);
            exp_q.push_back(e);
        end
    endtask

    task automatic set_freq(input int unsigned f);
        bus.newFreq = f[19:0];
        model_update();
    endtask

    task automatic drop_link();
        bus.swiptAlive = 1'b0;
        req_model = 0;
        exp_q.delete();
        meas_abort = 1'b1;
    endtask

    task automatic drain(input string name);
        int i;
        for (i = 0; i < 20000 && exp_q.size() != 0; i++) @(negedge clk);
        check({name, "_drain_timeout"}, exp_q.size(), 0);
    endtask

    task automatic wait_pstart(input string name);
        int i;
        for (i = 0; i < 12000; i++) begin
            @(negedge clk);
            if (bus.periodStart) break;
        end
        if (i == 12000) check({name, "_pstart_timeout"}, 0, 1);
    endtask

    // First edge is the latch edge; returns how many edges later driveA is first seen high.
    task automatic wait_rise_a(output int edges);
        edges = 0;
        @(posedge clk);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.driveA) break;
        end
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_driveA"}, bus.driveA, 0);
        check({name, "_driveB"}, bus.driveB, 0);
        check({name, "_pstart"}, bus.periodStart, 0);
        check({name, "_freqApplied"}, bus.freqApplied, 0);
        check({name, "_halfPeriod"}, bus.halfPeriod, 0);
        check({name, "_locked"}, bus.locked, 0);
    endtask

    task automatic reset_pulse(input string name);
        @(posedge clk); #1;
        rst = 1'b1;
        req_model = 0;
        exp_q.delete();
        meas_abort = 1'b1;
        @(posedge clk); #1;
        check_all_zero(name);
        rst = 1'b0;
        model_update();
    endtask

    // Monitor: scoreboard pops, per-period timing and dead-gap/overlap checks.
    initial begin : monitor
        int          len, a_cnt, b_cnt, per_h, gap;
        int unsigned exp_hp_cur, last_fa, last_hp;
        bit          meas_active, resync, a_prev, b_prev;
        exp_t        e;
        len = 0; a_cnt = 0; b_cnt = 0; per_h = 0; gap = 1000;
        exp_hp_cur = 0; last_fa = 0; last_hp = 0;
        meas_active = 1'b0; resync = 1'b1; a_prev = 1'b0; b_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (meas_abort) begin
                meas_abort  = 1'b0;
                meas_active = 1'b0;
                resync      = 1'b1;
            end
            if (bus.driveA && !a_prev) begin
                check("dead_gap_before_A", (gap >= DEAD) ? 1 : 0, 1);
                check("overlap_at_A_rise", bus.driveB, 0);
            end
            if (bus.driveB && !b_prev) begin
                check("dead_gap_before_B", (gap >= DEAD) ? 1 : 0, 1);
                check("overlap_at_B_rise", bus.driveA, 0);
            end
            gap    = (!bus.driveA && !bus.driveB) ? gap + 1 : 0;
            a_prev = bus.driveA;
            b_prev = bus.driveB;

            if (rst || !bus.swiptAlive) begin
                meas_active = 1'b0;
            end else if (bus.periodStart) begin
                if (meas_active) begin
                    check("period_len", len, 2 * per_h);
                    check("driveA_high", a_cnt, per_h - DEAD);
                    check("driveB_high", b_cnt, per_h - DEAD);
                end
                if (resync || bus.freqApplied != last_fa || bus.halfPeriod != last_hp) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_apply_halfPeriod", bus.halfPeriod, last_hp);
                    end else begin
                        e = exp_q.pop_front();
                        check("applied_freq", bus.freqApplied, e.f);
                        check("applied_halfPeriod", bus.halfPeriod, e.hp);
                        exp_hp_cur = e.hp;
                    end
                    last_fa = bus.freqApplied;
                    last_hp = bus.halfPeriod;
                    resync  = 1'b0;
                end
                per_h       = exp_hp_cur;
                meas_active = 1'b1;
                len         = 1;
                a_cnt       = bus.driveA;
                b_cnt       = bus.driveB;
            end else if (meas_active) begin
                len++;
                a_cnt += bus.driveA;
                b_cnt += bus.driveB;
            end
        end
    end

    initial begin : watchdog
        #950000;
        $display("FAIL watchdog: simulation exceeded its cycle budget");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int edges;
        bus.swiptAlive = 1'b0;
        bus.newFreq    = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");

        // Startup at 100 kHz
        bus.newFreq    = 20'd100000;
        bus.swiptAlive = 1'b1;
        rst            = 1'b0;
        model_update();
        wait_rise_a(edges);
        check("startup_latency", edges, 33);
        check("startup_pstart", bus.periodStart, 1);
        check("startup_halfPeriod", bus.halfPeriod, 500);
        check("startup_locked", bus.locked, 1);
        drain("startup");
        wait_pstart("startup");
        wait_pstart("startup2");

        // Mid-period change at cnt 200
        wait_pstart("mid");
        repeat (199) @(posedge clk);
        #1;
        set_freq(85000);
        @(posedge clk); #1;
        check("mid_locked_divide", bus.locked, 0);
        repeat (40) @(posedge clk);
        #1;
        check("mid_locked_pending", bus.locked, 0);
        check("mid_old_halfPeriod", bus.halfPeriod, 500);
        drain("mid");
        @(posedge clk); #1;
        check("mid_locked_after_swap", bus.locked, 1);
        wait_pstart("mid2");

        // Clamping both ways
        @(posedge clk); #1;
        set_freq(0);
        drain("clamp_low");
        wait_pstart("clamp_low");
        @(posedge clk); #1;
        set_freq(900000);
        drain("clamp_high");
        wait_pstart("clamp_high");

        // Link drop while driveA is high, then re-raise with same request
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.driveA) break;
        end
        @(posedge clk); #1;
        drop_link();
        @(posedge clk); #1;
        check("drop_driveA", bus.driveA, 0);
        check("drop_driveB", bus.driveB, 0);
        check("drop_pstart", bus.periodStart, 0);
        check("drop_hold_freq", bus.freqApplied, 500000);
        check("drop_hold_halfPeriod", bus.halfPeriod, 100);
        edges = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            edges += (bus.driveA || bus.driveB) ? 1 : 0;
        end
        check("drop_stays_off", edges, 0);
        bus.swiptAlive = 1'b1;
        model_update();
        wait_rise_a(edges);
        check("reraise_latency", edges, 33);
        drain("reraise");
        wait_pstart("reraise");

        // Change during an IDLE-entered divide: first request must never be applied
        @(posedge clk); #1;
        drop_link();
        repeat (5) @(posedge clk);
        #1;
        bus.newFreq    = 20'd100000;
        bus.swiptAlive = 1'b1;
        model_update();
        repeat (16) @(posedge clk);
        #1;
        exp_q.delete();
        set_freq(50000);
        wait_rise_a(edges);
        check("abort_restart_latency", edges, 33);
        check("abort_halfPeriod", bus.halfPeriod, 1000);
        drain("abort");
        wait_pstart("abort");

        // Reset while running, then while dividing from RUN
        reset_pulse("rst_run");
        drain("rst_run");
        wait_pstart("rst_run");
        @(posedge clk); #1;
        set_freq(300000);
        repeat (10) @(posedge clk);
        reset_pulse("rst_divide");
        drain("rst_divide");
        wait_pstart("rst_divide");

        // Random sweep, including out-of-range requests
        for (int k = 0; k < 10; k++) begin
            repeat ($urandom_range(300, 1)) @(posedge clk);
            #1;
            set_freq($urandom_range(560000, 0));
            drain("sweep");
            wait_pstart("sweep");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
